// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dp_pkg
//  Description : Shared dataplane definitions. Provides the port-index width
//                helper, the ingress arbiter state enum and an Avalon-ST beat
//                struct for the default 32-bit, two-port configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
package dp_pkg;

    localparam int c_dp_data_width  = 32;
    localparam int c_dp_empty_width = 2;
    localparam int c_dp_port_width  = 1;

    // Width of a port index: clog2(n), never narrower than one bit.
    function automatic int port_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Avalon-ST beat at the default widths.
    typedef struct packed {
        logic [c_dp_data_width-1:0]  data;
        logic                        sop;
        logic                        eop;
        logic [c_dp_empty_width-1:0] empty;
        logic [c_dp_port_width-1:0]  port;
    } dp_beat_t;

endpackage
`default_nettype wire

// File: rtl/dp_rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : dp_rr_select
//  Description : Combinational round-robin priority picker. Searches req
//                starting at ptr+1, wrapping modulo N, and grants the first
//                requester found.
//  Ports       : req        - request vector
//                ptr        - index of the most recent winner
//                gnt_onehot - one-hot grant (all zero when nothing requests)
//                gnt_idx    - binary index of the grant (0 when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module dp_rr_select
    import dp_pkg::*;
#(
    parameter int N     = 2,
    parameter int PTR_W = port_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt_onehot,
    output logic [PTR_W-1:0] gnt_idx
);

    always_comb begin
        logic             v_found;
        logic [PTR_W-1:0] v_idx;
        v_found    = 1'b0;
        v_idx      = '0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        for (int k = 1; k <= N; k++) begin
            v_idx = PTR_W'((int'(ptr) + k) % N);
            if (!v_found && req[v_idx]) begin
                v_found             = 1'b1;
                gnt_onehot[v_idx]   = 1'b1;
                gnt_idx             = v_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dp_ingress_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dp_ingress_arbiter
//  Description : Packet-granular round-robin merge of N_PORTS Avalon-ST RX
//                streams into one dataplane ingress stream. A grant is held
//                from SOP to EOP; every output beat carries its source port.
//                Enabled non-SOP beats seen in IDLE are framing errors and are
//                acked and discarded.
//  Ports       : clk, rst                     - clock, sync active-high reset
//                in_data/valid/ready/sop/eop/empty - per-port input streams
//                port_en                      - per-port arbitration enable
//                out_data/valid/ready/sop/eop/empty/port - merged stream
//                busy                         - high while a packet is locked
//                pkt_cnt, drop_cnt, stats_clr - statistics, present only when
//                                               DP_INGRESS_ARB_STATS_EN is defined
//  Revision    : 1.0 - initial release
// ============================================================================
module dp_ingress_arbiter
    import dp_pkg::*;
#(
    parameter int N_PORTS     = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = 2,
    parameter int PORT_W      = port_w(N_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_PORTS*DATA_WIDTH-1:0]  in_data,
    input  logic [N_PORTS-1:0]             in_valid,
    output logic [N_PORTS-1:0]             in_ready,
    input  logic [N_PORTS-1:0]             in_sop,
    input  logic [N_PORTS-1:0]             in_eop,
    input  logic [N_PORTS*EMPTY_WIDTH-1:0] in_empty,
    input  logic [N_PORTS-1:0]             port_en,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_sop,
    output logic                           out_eop,
    output logic [EMPTY_WIDTH-1:0]         out_empty,
    output logic [PORT_W-1:0]              out_port,
`ifdef DP_INGRESS_ARB_STATS_EN
    input  logic                           stats_clr,
    output logic [N_PORTS*32-1:0]          pkt_cnt,
    output logic [N_PORTS*16-1:0]          drop_cnt,
`endif
    output logic                           busy
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [EMPTY_WIDTH-1:0] empty;
        logic [PORT_W-1:0]      port;
    } beat_t;

    arb_state_t        r_state;
    logic [PORT_W-1:0] r_ptr;
    logic [PORT_W-1:0] r_grant;
    logic              r_out_valid;
    beat_t             r_out;
    logic              r_busy;

    logic               w_slot_free;
    logic [N_PORTS-1:0] w_eligible;
    logic [N_PORTS-1:0] w_frame_err;
    logic [N_PORTS-1:0] w_sel_onehot;
    logic [PORT_W-1:0]  w_sel_idx;
    logic               w_sel_any;
    logic [PORT_W-1:0]  w_cur_idx;
    logic               w_take;
    beat_t              w_beat;

    // The output register can load when empty or draining this cycle.
    assign w_slot_free = !r_out_valid || out_ready;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_req
        localparam logic [PORT_W-1:0] c_idx = PORT_W'(i);

        assign w_eligible[i]  = in_valid[i] && in_sop[i] && port_en[i];
        assign w_frame_err[i] = in_valid[i] && !in_sop[i] && port_en[i];

        // In IDLE a port is acked either as the SOP winner or as a framing
        // error being flushed; in LOCKED only the granted port is served.
        assign in_ready[i] = w_slot_free &&
                             ((r_state == IDLE) ? (w_sel_onehot[i] || w_frame_err[i])
                                                : (r_grant == c_idx));
    end

    dp_rr_select #(
        .N     (N_PORTS),
        .PTR_W (PORT_W)
    ) u_rr_select (
        .req        (w_eligible),
        .ptr        (r_ptr),
        .gnt_onehot (w_sel_onehot),
        .gnt_idx    (w_sel_idx)
    );

    assign w_sel_any = |w_sel_onehot;
    assign w_cur_idx = (r_state == IDLE) ? w_sel_idx : r_grant;
    assign w_take    = w_slot_free && ((r_state == IDLE) ? w_sel_any : in_valid[r_grant]);

    always_comb begin
        w_beat = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_cur_idx == PORT_W'(i)) begin
                w_beat.data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_beat.sop   = in_sop[i];
                w_beat.eop   = in_eop[i];
                w_beat.empty = in_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
            end
        end
        w_beat.port = w_cur_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= PORT_W'(N_PORTS - 1);
            r_grant     <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_busy      <= 1'b0;
        end else begin
            if (w_slot_free) begin
                r_out_valid <= w_take;
                if (w_take) begin
                    r_out <= w_beat;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_ptr   <= w_sel_idx;
                        r_grant <= w_sel_idx;
                        // A single-beat packet never leaves IDLE.
                        if (!w_beat.eop) begin
                            r_state <= LOCKED;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    // Enable changes and stray SOPs are ignored until EOP.
                    if (w_take && w_beat.eop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out.data;
    assign out_sop   = r_out.sop;
    assign out_eop   = r_out.eop;
    assign out_empty = r_out.empty;
    assign out_port  = r_out.port;
    assign busy      = r_busy;

`ifdef DP_INGRESS_ARB_STATS_EN
    for (genvar i = 0; i < N_PORTS; i++) begin : g_stats
        localparam logic [PORT_W-1:0] c_idx = PORT_W'(i);

        logic [31:0] r_pkt_cnt;
        logic [15:0] r_drop_cnt;
        logic        w_fwd_eop;
        logic        w_drop;

        assign w_fwd_eop = w_take && w_beat.eop && (w_cur_idx == c_idx);
        assign w_drop    = w_slot_free && (r_state == IDLE) && w_frame_err[i];

        always_ff @(posedge clk) begin
            if (rst || stats_clr) begin
                r_pkt_cnt  <= '0;
                r_drop_cnt <= '0;
            end else begin
                if (w_fwd_eop) begin
                    r_pkt_cnt <= r_pkt_cnt + 32'd1;
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end

        assign pkt_cnt[i*32 +: 32]  = r_pkt_cnt;
        assign drop_cnt[i*16 +: 16] = r_drop_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dp_ingress_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dp_ingress_arbiter
//  Description : Self-checking bench for dp_ingress_arbiter. Per-port sources
//                replay queued beats; a reference model predicts in_ready and
//                the merged stream, pushing expected beats into a scoreboard
//                that an independent monitor drains.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_ingress_arbiter;

    localparam int N     = 2;
    localparam int DW    = 32;
    localparam int EW    = 2;
    localparam int PW    = 1;
    localparam int DEPTH = 512;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } src_beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic [PW-1:0] port;
    } out_beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DW-1:0] in_data  = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    in_sop   = '0;
    logic [N-1:0]    in_eop   = '0;
    logic [N*EW-1:0] in_empty = '0;
    logic [N-1:0]    port_en  = '1;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            out_sop;
    logic            out_eop;
    logic [EW-1:0]   out_empty;
    logic [PW-1:0]   out_port;
    logic            busy;
`ifdef DP_INGRESS_ARB_STATS_EN
    logic            stats_clr = 1'b0;
    logic [N*32-1:0] pkt_cnt;
    logic [N*16-1:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    dp_ingress_arbiter #(
        .N_PORTS     (N),
        .DATA_WIDTH  (DW),
        .EMPTY_WIDTH (EW),
        .PORT_W      (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_empty  (in_empty),
        .port_en   (port_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_empty (out_empty),
        .out_port  (out_port),
`ifdef DP_INGRESS_ARB_STATS_EN
        .stats_clr (stats_clr),
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt),
`endif
        .busy      (busy)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [N-1:0] v, input int i);
        logic [PW-1:0] idx;
        idx = PW'(i);
        return v[idx];
    endfunction

    // ---------------- sources ----------------
    src_beat_t   src_mem [N][DEPTH];
    int          src_wr [N];
    int          src_rd [N];
    logic [N-1:0] hs = '0;
    logic [N-1:0] vld = '0;
    int          gap_pct  = 0;
    int          rdy_mode = 0;
    int          rdy_cnt  = 0;

    task automatic enq_beat(input int p, input src_beat_t b);
        src_mem[p][src_wr[p] % DEPTH] = b;
        src_wr[p]++;
    endtask

    task automatic enq_pkt(input int p, input int len, input logic [DW-1:0] base,
                           input logic [EW-1:0] last_empty, input bit rnd);
        src_beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = rnd ? DW'($urandom) : base + DW'(i);
            b.sop   = (i == 0);
            b.eop   = (i == len - 1);
            b.empty = (i == len - 1) ? last_empty : '0;
            enq_beat(p, b);
        end
    endtask

    // Handshakes are sampled mid-cycle, when inputs and DUT state are stable.
    always @(negedge clk) begin
        hs = rst ? '0 : (in_valid & in_ready);
    end

    initial begin
        for (int p = 0; p < N; p++) begin
            src_wr[p] = 0;
            src_rd[p] = 0;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int p = 0; p < N; p++) begin
                src_beat_t b;
                if (rst) begin
                    src_rd[p] = src_wr[p];
                    vld[p]    = 1'b0;
                end else begin
                    if (hs[p]) begin
                        src_rd[p]++;
                        vld[p] = 1'b0;
                    end
                    if (!vld[p] && src_rd[p] != src_wr[p] && int'($urandom_range(99)) >= gap_pct)
                        vld[p] = 1'b1;
                end
                b = src_mem[p][src_rd[p] % DEPTH];
                in_valid[p]            = vld[p];
                in_data[p*DW +: DW]    = b.data;
                in_sop[p]              = b.sop;
                in_eop[p]              = b.eop;
                in_empty[p*EW +: EW]   = b.empty;
            end
            case (rdy_mode)
                1:       out_ready = ($urandom_range(99) < 70);
                2: begin
                    out_ready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
                    rdy_cnt++;
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- reference model ----------------
    out_beat_t exp_q[$];
    int        sop_log[$];
    bit        m_ov     = 0;
    bit        m_locked = 0;
    int        m_ptr    = N - 1;
    int        m_grant  = 0;
    bit        pend_take = 0;
    bit        pend_slot = 0;
    int        pend_port = 0;
    out_beat_t pend_beat;
    logic [N-1:0] pend_drop = '0;
    logic [31:0] m_pkt  [N];
    logic [15:0] m_drop [N];

    always @(negedge clk) begin
        bit           slot;
        bit           found;
        int           sel;
        logic [N-1:0] pr;
        pend_take = 0;
        pend_slot = 0;
        pend_drop = '0;
        if (!rst) begin
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            chk("busy", 64'(busy), 64'(m_locked));
            slot  = !m_ov || out_ready;
            pr    = '0;
            found = 0;
            sel   = 0;
            if (!m_locked) begin
                for (int p = 0; p < N; p++) begin
                    if (bit_of(in_valid, p) && !bit_of(in_sop, p) && bit_of(port_en, p) && slot) begin
                        pr[p]        = 1'b1;
                        pend_drop[p] = 1'b1;
                    end
                end
                for (int k = 1; k <= N; k++) begin
                    int q;
                    q = (m_ptr + k) % N;
                    if (!found && bit_of(in_valid, q) && bit_of(in_sop, q) && bit_of(port_en, q)) begin
                        found = 1;
                        sel   = q;
                    end
                end
                if (found && slot) begin
                    pr[sel]   = 1'b1;
                    pend_take = 1;
                end
            end else begin
                sel = m_grant;
                if (slot) pr[sel] = 1'b1;
                pend_take = slot && bit_of(in_valid, sel);
            end
            chk("in_ready", 64'(in_ready), 64'(pr));
            pend_slot       = slot;
            pend_port       = sel;
            pend_beat.data  = in_data[sel*DW +: DW];
            pend_beat.sop   = bit_of(in_sop, sel);
            pend_beat.eop   = bit_of(in_eop, sel);
            pend_beat.empty = in_empty[sel*EW +: EW];
            pend_beat.port  = PW'(sel);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_ov     = 0;
            m_locked = 0;
            m_ptr    = N - 1;
            m_grant  = 0;
            exp_q.delete();
            for (int p = 0; p < N; p++) begin
                m_pkt[p]  = '0;
                m_drop[p] = '0;
            end
        end else begin
            if (pend_slot) m_ov = pend_take;
            if (pend_take) begin
                exp_q.push_back(pend_beat);
                if (!m_locked) begin
                    m_ptr   = pend_port;
                    m_grant = pend_port;
                end
                m_locked = !pend_beat.eop;
            end
`ifdef DP_INGRESS_ARB_STATS_EN
            if (stats_clr) begin
                for (int p = 0; p < N; p++) begin
                    m_pkt[p]  = '0;
                    m_drop[p] = '0;
                end
            end else begin
                if (pend_take && pend_beat.eop) m_pkt[pend_port] = m_pkt[pend_port] + 32'd1;
                for (int p = 0; p < N; p++)
                    if (pend_drop[p]) m_drop[p] = m_drop[p] + 16'd1;
            end
`endif
        end
    end

    // ---------------- monitor ----------------
    bit        mon_stall = 0;
    out_beat_t mon_held;

    always @(negedge clk) begin
        out_beat_t cur;
        out_beat_t exp;
        if (rst) begin
            mon_stall = 0;
        end else begin
            cur = {out_data, out_sop, out_eop, out_empty, out_port};
            if (out_valid && mon_stall)
                chk("stall_hold", 64'(cur), 64'(mon_held));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_beat: got beat %0h, expected no beat (t=%0t)", cur, $time);
                end else begin
                    exp = exp_q.pop_front();
                    chk("out_beat", 64'(cur), 64'(exp));
                end
                if (out_sop) sop_log.push_back(int'(out_port));
            end
            mon_stall = out_valid && !out_ready;
            mon_held  = cur;
        end
    end

    // ---------------- sequencing ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int n;
        n = 0;
        while (n < budget && !(src_rd[0] == src_wr[0] && src_rd[1] == src_wr[1] &&
                               exp_q.size() == 0 && !out_valid)) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            vectors++;
            errors++;
            $display("FAIL %s_timeout: got %0d queued beats, expected 0", nm, exp_q.size());
        end
    endtask

`ifdef DP_INGRESS_ARB_STATS_EN
    task automatic chk_stats(input string nm);
        chk({nm, "_pkt"}, 64'(pkt_cnt), {m_pkt[1], m_pkt[0]});
        chk({nm, "_drop"}, 64'(drop_cnt), 64'({m_drop[1], m_drop[0]}));
    endtask
`endif

    initial begin
        int n;
        int base;
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_port", 64'(out_port), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        tick();

        // Single 4-beat packet on port 0.
        enq_pkt(0, 4, 32'h11, 2'd2, 0);
        wait_drain(200, "single");

        // Contending ports alternate packet by packet from a fresh reset.
        do_reset();
        sop_log.delete();
        for (int r = 0; r < 3; r++) begin
            enq_pkt(0, 3, 32'h100 + 32'(r * 16), 2'd1, 0);
            enq_pkt(1, 3, 32'h200 + 32'(r * 16), 2'd3, 0);
        end
        wait_drain(300, "rr");
        chk("rr_sop_count", 64'(sop_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < sop_log.size(); i++)
            chk("rr_order", 64'(sop_log[i]), 64'(i % 2));

        // Backpressure pattern during a packet.
        rdy_mode = 2;
        rdy_cnt  = 0;
        enq_pkt(0, 6, 32'h300, 2'd0, 0);
        wait_drain(300, "stall");
        rdy_mode = 0;

        // Disabled port is held off; enable drop mid-packet is ignored.
        port_en = 2'b01;
        enq_pkt(1, 3, 32'h400, 2'd0, 0);
        repeat (10) tick();
        base = src_rd[0];
        enq_pkt(0, 6, 32'h500, 2'd1, 0);
        n = 0;
        while (!busy && n < 100) begin tick(); n++; end
        port_en = 2'b00;
        n = 0;
        while (src_rd[0] != base + 6 && n < 100) begin tick(); n++; end
        if (n >= 100) begin
            vectors++;
            errors++;
            $display("FAIL en_drop_timeout: got %0d beats, expected 6", src_rd[0] - base);
        end
        port_en = 2'b11;
        wait_drain(300, "en");

        // Framing errors on port 1, then a single-beat packet on port 0.
        enq_beat(1, '{data: 32'hBAD0, sop: 1'b0, eop: 1'b0, empty: 2'd0});
        enq_beat(1, '{data: 32'hBAD1, sop: 1'b0, eop: 1'b0, empty: 2'd0});
        wait_drain(200, "frame");
        enq_pkt(0, 1, 32'h600, 2'd3, 0);
        wait_drain(200, "one_beat");
`ifdef DP_INGRESS_ARB_STATS_EN
        chk_stats("stats_directed");
`endif

        // Reset in the middle of a 5-beat packet.
        base = src_rd[0];
        enq_pkt(0, 5, 32'h700, 2'd2, 0);
        n = 0;
        while (src_rd[0] < base + 2 && n < 100) begin tick(); n++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        tick();
        enq_pkt(1, 3, 32'h800, 2'd1, 0);
        wait_drain(200, "post_rst");

        // Randomised traffic, enables, gaps and backpressure.
        rdy_mode = 1;
        gap_pct  = 30;
        for (int c = 0; c < 2000; c++) begin
            int p;
            p = int'($urandom_range(N - 1));
            if ((src_wr[p] - src_rd[p]) < DEPTH - 16) begin
                if ($urandom_range(99) < 12)
                    enq_pkt(p, int'($urandom_range(1, 6)), '0, EW'($urandom), 1);
                else if ($urandom_range(99) < 3)
                    enq_beat(p, '{data: DW'($urandom), sop: 1'b0, eop: 1'($urandom), empty: '0});
            end
            if ($urandom_range(99) < 4) port_en = N'($urandom);
`ifdef DP_INGRESS_ARB_STATS_EN
            stats_clr = (c == 1000);
`endif
            tick();
        end
        port_en  = '1;
        rdy_mode = 0;
        gap_pct  = 0;
        wait_drain(5000, "random");
`ifdef DP_INGRESS_ARB_STATS_EN
        chk_stats("stats_random");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
